// File: rtl/abs_sign_split_if.sv
// Valid/ready bundle for abs_sign_split: signed words in, sign/magnitude/clip flag out.
interface abs_sign_split_if #(
  parameter int BW_IN  = 32,
  parameter int BW_OUT = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [BW_IN-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [BW_OUT-1:0] out_mag;
  logic              out_sign;
  logic              out_sat;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_mag, out_sign, out_sat
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_mag, out_sign, out_sat
  );
endinterface

// File: rtl/abs_sign_split.sv
// Two's-complement to sign-magnitude stream converter, 2-entry (output + skid) buffer.
// Optional saturation event counter enabled by defining ABS_SAT_COUNT_EN.
module abs_sign_split #(
  parameter int BW_IN  = 32,
  parameter int BW_OUT = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  abs_sign_split_if.slave  bus,
  input  logic             sat_clr,
  output logic [CNT_W-1:0] sat_count
);
  typedef struct packed {
    logic              sign;
    logic              sat;
    logic [BW_OUT-1:0] mag;
  } word_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  // Magnitude is formed one bit wider than the input so the most-negative value is exact.
  function automatic word_t convert(input logic [BW_IN-1:0] d);
    logic [BW_IN:0] ext;
    logic [BW_IN:0] mag;
    word_t          w;
    ext    = {d[BW_IN-1], d};
    mag    = d[BW_IN-1] ? (~ext + 1'b1) : ext;
    w.sign = d[BW_IN-1];
    w.sat  = (mag >> BW_OUT) != '0;
    w.mag  = w.sat ? '1 : mag[BW_OUT-1:0];
    return w;
  endfunction

  state_t state_q, state_d;
  word_t  out_q, skid_q, in_word;
  logic   in_rdy_q;
  logic   in_fire, out_fire, out_valid;
  logic   load_out, load_skid, skid_to_out;

  assign in_word   = convert(bus.in_data);
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = bus.in_valid & in_rdy_q;
  assign out_fire  = out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    case (state_q)
      EMPTY: if (in_fire) begin
        state_d  = ONE;
        load_out = 1'b1;
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_out = 1'b1;
        end else if (in_fire) begin
          state_d   = TWO;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: if (out_fire) begin
        state_d     = ONE;
        skid_to_out = 1'b1;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Ready is a flop copy of the next state so it never depends on inputs combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= '0;
      skid_q   <= '0;
      in_rdy_q <= 1'b1;
    end else begin
      if (load_out)         out_q <= in_word;
      else if (skid_to_out) out_q <= skid_q;
      if (load_skid)        skid_q <= in_word;
      in_rdy_q <= (state_d != TWO);
    end
  end

  assign bus.in_ready  = in_rdy_q;
  assign bus.out_valid = out_valid;
  assign bus.out_mag   = out_q.mag;
  assign bus.out_sign  = out_q.sign;
  assign bus.out_sat   = out_q.sat;

`ifdef ABS_SAT_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    cnt_q <= '0;
    else if (sat_clr)                              cnt_q <= '0;
    else if (out_fire && out_q.sat && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  end

  assign sat_count = cnt_q;
`else
  logic unused_sat_clr;
  assign unused_sat_clr = sat_clr;
  assign sat_count      = '0;
`endif
endmodule

// File: tb/tb_abs_sign_split.sv
// Directed bench for abs_sign_split: DUT a (8->7, CNT_W=2) exercises clipping and flow control,
// DUT b (8->9) covers the exact most-negative magnitude.
module tb_abs_sign_split;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sat_clr_a = 1'b0, sat_clr_b = 1'b0;
  logic [1:0]  cnt_a;
  logic [15:0] cnt_b;
  int passed = 0, total = 0;

`ifdef ABS_SAT_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  abs_sign_split_if #(.BW_IN(8), .BW_OUT(7)) ia ();
  abs_sign_split_if #(.BW_IN(8), .BW_OUT(9)) ib ();

  abs_sign_split #(.BW_IN(8), .BW_OUT(7), .CNT_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia), .sat_clr(sat_clr_a), .sat_count(cnt_a));
  abs_sign_split #(.BW_IN(8), .BW_OUT(9), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib), .sat_clr(sat_clr_b), .sat_count(cnt_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Packed {valid, sign, sat, mag[6:0]} of DUT a
  function automatic logic [9:0] obs_a();
    return {ia.out_valid, ia.out_sign, ia.out_sat, ia.out_mag};
  endfunction

  // Reference for the 8->7 configuration: {sign, sat, mag}
  function automatic logic [8:0] model_a(input logic [7:0] d);
    int v, m;
    logic s;
    v = int'($signed(d));
    s = (v < 0);
    m = s ? -v : v;
    if (m > 127) return {s, 1'b1, 7'h7f};
    return {s, 1'b0, 7'(m)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [8:0] sbq[$];
  logic [8:0] exp_w;

  initial begin
    int sent, cyc;
    bit in_f, out_f;
    ia.in_valid = 0; ia.in_data = '0; ia.out_ready = 1;
    ib.in_valid = 0; ib.in_data = '0; ib.out_ready = 1;

    // Reset state
    #12;
    chk("rst_a", obs_a(), 10'h000);
    chk("rst_rdy_a", ia.in_ready, 1);
    chk("rst_b", {ib.out_valid, ib.out_sign, ib.out_sat, ib.out_mag, ib.in_ready}, 13'h001);
    chk("rst_cnt", cnt_a, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // Basic stream, out_ready held high
    ia.in_valid = 1; ia.in_data = 8'd5;   tick(); chk("b5",    obs_a(), {1'b1, 2'b00, 7'd5});
    ia.in_data = 8'hfb;                   tick(); chk("bm5",   obs_a(), {1'b1, 2'b10, 7'd5});
    ia.in_data = 8'h00;                   tick(); chk("b0",    obs_a(), {1'b1, 2'b00, 7'd0});
    ia.in_data = 8'h80;                   tick(); chk("bm128", obs_a(), {1'b1, 2'b11, 7'd127});
    ia.in_valid = 0;                      tick(); chk("b_drain", ia.out_valid, 0);
    chk("b_cnt", cnt_a, CNT_EN ? 2'd1 : 2'd0);

    // Wider output: most-negative fits unclipped
    ib.in_valid = 1; ib.in_data = 8'h80; tick();
    chk("w_m128", {ib.out_valid, ib.out_sign, ib.out_sat, ib.out_mag}, {3'b110, 9'd128});
    ib.in_data = 8'd127; tick();
    chk("w_127", {ib.out_valid, ib.out_sign, ib.out_sat, ib.out_mag}, {3'b100, 9'd127});
    ib.in_valid = 0; tick();
    chk("w_drain", ib.out_valid, 0);

    // Backpressure: fill both entries, then drain in order
    ia.out_ready = 0; ia.in_valid = 1; ia.in_data = 8'd10; tick();
    chk("bp1", obs_a(), {1'b1, 2'b00, 7'd10}); chk("bp1_rdy", ia.in_ready, 1);
    ia.in_data = 8'd20; tick();
    chk("bp2", obs_a(), {1'b1, 2'b00, 7'd10}); chk("bp2_rdy", ia.in_ready, 0);
    ia.in_data = 8'd30; tick();
    chk("bp3", obs_a(), {1'b1, 2'b00, 7'd10}); chk("bp3_rdy", ia.in_ready, 0);
    ia.out_ready = 1; tick();
    chk("bp4", obs_a(), {1'b1, 2'b00, 7'd20}); chk("bp4_rdy", ia.in_ready, 1);
    tick();
    chk("bp5", obs_a(), {1'b1, 2'b00, 7'd30});
    ia.in_valid = 0; tick();
    chk("bp6", ia.out_valid, 0);

    // Counter: five more clipped words stick at 3, then clear beats a coinciding increment
    ia.in_valid = 1; ia.in_data = 8'h80;
    repeat (5) tick();
    ia.in_valid = 0; tick();
    chk("cnt_stick", cnt_a, CNT_EN ? 2'd3 : 2'd0);
    ia.in_valid = 1; tick();
    ia.in_valid = 0; sat_clr_a = 1; tick();
    sat_clr_a = 0;
    chk("cnt_clr", cnt_a, 0);
    chk("cnt_clr_drain", ia.out_valid, 0);

    // Random valid/ready, 1000 words against a scoreboard
    sent = 0; cyc = 0;
    while ((sent < 1000 || sbq.size() != 0) && cyc < 20000) begin
      ia.in_valid  = (sent < 1000) && ($urandom_range(3) != 0);
      ia.in_data   = 8'($urandom);
      ia.out_ready = ($urandom_range(2) != 0);
      in_f  = ia.in_valid && ia.in_ready;
      out_f = ia.out_valid && ia.out_ready;
      if (out_f) begin
        if (sbq.size() == 0) chk("rnd_extra", 1, 0);
        else begin
          exp_w = sbq.pop_front();
          chk("rnd_word", {ia.out_sign, ia.out_sat, ia.out_mag}, exp_w);
        end
      end
      if (in_f) begin
        sbq.push_back(model_a(ia.in_data));
        sent++;
      end
      tick();
      cyc++;
    end
    chk("rnd_timeout", cyc < 20000, 1);
    chk("rnd_sent", sent, 1000);
    ia.in_valid = 0; ia.out_ready = 1; tick();
    chk("rnd_empty", ia.out_valid, 0);

    // Reset while holding two words
    ia.out_ready = 0; ia.in_valid = 1; ia.in_data = 8'h80; tick();
    ia.in_data = 8'd9; tick();
    chk("mr_full", ia.in_ready, 0);
    rst_n = 0; #1;
    chk("mr_vld", ia.out_valid, 0);
    chk("mr_rdy", ia.in_ready, 1);
    chk("mr_cnt", cnt_a, 0);
    ia.in_valid = 0; ia.out_ready = 1;
    @(negedge clk); rst_n = 1;
    ia.in_valid = 1; ia.in_data = 8'd7;
    tick();
    chk("mr_7", obs_a(), {1'b1, 2'b00, 7'd7});
    ia.in_valid = 0; tick();
    chk("mr_drain", ia.out_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
